// File: rtl/alarm_key_ctrl.sv
// Alarm clock keypad controller: collects up to four digits from the keypad,
// then loads them into the alarm or current-time register on a button press.
// Entry is abandoned after TIMEOUT_SEC seconds without a new key.
module alarm_key_ctrl #(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter logic [3:0]  NOKEY       = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       show_a,
  output logic       key_clear,
  output logic [2:0] digit_cnt
);

  localparam int unsigned SecW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [SecW-1:0] SecMax = SecW'(TIMEOUT_SEC);

  typedef enum logic [2:0] {
    StShowTime,
    StKeyStored,
    StKeyWaited,
    StKeyEntered,
    StShowAlarm,
    StSetAlarm,
    StSetTime
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      digit_cnt_q, digit_cnt_d;
  logic [SecW-1:0] sec_cnt_q, sec_cnt_d;
  logic            key_clear_q, key_clear_d;
  logic            key_valid;
  logic            timeout;
  logic            four_digits;

  // Only digit codes count as a key press; the designated no-key code never does.
  assign key_valid   = (key != NOKEY) && (key <= 4'd9);
  assign timeout     = (sec_cnt_q == SecMax);
  assign four_digits = (digit_cnt_q == 3'd4);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StShowTime: begin
        if (alarm_button)   state_d = StShowAlarm;
        else if (key_valid) state_d = StKeyStored;
      end
      StShowAlarm: begin
        if (!alarm_button) state_d = StShowTime;
      end
      StKeyStored: state_d = StKeyWaited;
      StKeyWaited: begin
        // Timeout wins even while a key is still held down.
        if (timeout)         state_d = StShowTime;
        else if (!key_valid) state_d = StKeyEntered;
      end
      StKeyEntered: begin
        if (timeout)                          state_d = StShowTime;
        else if (alarm_button && four_digits) state_d = StSetAlarm;
        else if (time_button && four_digits)  state_d = StSetTime;
        else if (key_valid)                   state_d = StKeyStored;
      end
      StSetAlarm: state_d = StShowTime;
      StSetTime:  state_d = StShowTime;
      default:    state_d = StShowTime;
    endcase
  end

  // Digit count, inactivity timer and key_clear strobe follow the state transition.
  always_comb begin
    digit_cnt_d = digit_cnt_q;
    if ((state_q == StKeyStored) && !four_digits) digit_cnt_d = digit_cnt_q + 3'd1;
    if (state_d == StShowTime) digit_cnt_d = 3'd0;

    // Timer runs only in the waiting states; any other next state clears it, so a
    // newly taken key restarts the inactivity window.
    sec_cnt_d = '0;
    if ((state_d == StKeyWaited) || (state_d == StKeyEntered)) begin
      sec_cnt_d = sec_cnt_q;
      if (one_second && !timeout) sec_cnt_d = sec_cnt_q + SecW'(1);
    end

    key_clear_d = (state_d == StShowTime) &&
                  ((state_q == StKeyWaited) || (state_q == StKeyEntered) ||
                   (state_q == StSetAlarm)  || (state_q == StSetTime));
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StShowTime;
      digit_cnt_q <= 3'd0;
      sec_cnt_q   <= '0;
      key_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      key_clear_q <= key_clear_d;
    end
  end

  // Moore outputs.
  always_comb begin
    shift         = (state_q == StKeyStored);
    load_new_a    = (state_q == StSetAlarm);
    load_new_c    = (state_q == StSetTime);
    show_new_time = (state_q == StKeyStored) || (state_q == StKeyWaited) ||
                    (state_q == StKeyEntered);
    show_a        = (state_q == StShowAlarm);
  end

  assign key_clear = key_clear_q;
  assign digit_cnt = digit_cnt_q;

endmodule

// File: tb/tb_alarm_key_ctrl.sv
// Self-checking bench for alarm_key_ctrl: a hand-written vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_alarm_key_ctrl;

  localparam int unsigned T = 10;
  localparam logic [3:0] NK = 4'd10;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift, load_new_a, load_new_c, show_new_time, show_a, key_clear;
  logic [2:0] digit_cnt;
  logic [8:0] dut_out;

  alarm_key_ctrl #(.TIMEOUT_SEC(T), .NOKEY(NK)) dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .shift        (shift),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c),
    .show_new_time(show_new_time),
    .show_a       (show_a),
    .key_clear    (key_clear),
    .digit_cnt    (digit_cnt)
  );

  always #5 clock = ~clock;

  // Packed view: {shift, load_a, load_c, show_new, show_a, key_clear, digit_cnt}
  assign dut_out = {shift, load_new_a, load_new_c, show_new_time, show_a, key_clear, digit_cnt};

  int vectors = 0;
  int miscompares = 0;
  int n_shift, n_la, n_lc, n_kc;

  // Behavioural model: mode of the controller, pending strobe, key-held flag,
  // idle seconds, digits collected and the key_clear flag.
  localparam int MTime = 0, MAlarm = 1, MEntry = 2, MLoad = 3;
  int m_mode, m_strobe, m_secs, m_digits;  // strobe: 0 none, 1 shift, 2 load a, 3 load c
  bit m_held, m_clear;

  function automatic logic [8:0] model_out();
    return {m_strobe == 1, m_strobe == 2, m_strobe == 3, m_mode == MEntry,
            m_mode == MAlarm, m_clear, 3'(m_digits)};
  endfunction

  task automatic model_reset();
    m_mode = MTime; m_strobe = 0; m_secs = 0; m_digits = 0; m_held = 0; m_clear = 0;
  endtask

  task automatic model_step(input logic [3:0] k, input bit a, input bit t, input bit s);
    bit valid, clr;
    valid = (k <= 4'd9);
    clr = 0;
    case (m_mode)
      MTime: begin
        if (a) m_mode = MAlarm;
        else if (valid) begin m_mode = MEntry; m_strobe = 1; m_held = 1; m_secs = 0; end
      end
      MAlarm: if (!a) m_mode = MTime;
      MEntry: begin
        if (m_strobe == 1) begin
          m_strobe = 0;
          if (m_digits < 4) m_digits++;
          m_secs = s ? 1 : 0;
        end else if (m_secs == T) begin
          m_mode = MTime; clr = 1; m_digits = 0; m_secs = 0; m_held = 0;
        end else if (m_held) begin
          if (!valid) m_held = 0;
          m_secs += int'(s);
        end else if (a && m_digits == 4) begin
          m_mode = MLoad; m_strobe = 2; m_secs = 0;
        end else if (t && m_digits == 4) begin
          m_mode = MLoad; m_strobe = 3; m_secs = 0;
        end else if (valid) begin
          m_strobe = 1; m_held = 1; m_secs = 0;
        end else begin
          m_secs += int'(s);
        end
      end
      default: begin  // MLoad
        m_mode = MTime; m_strobe = 0; clr = 1; m_digits = 0;
      end
    endcase
    m_clear = clr;
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (sh la lc sn sa kc dc)", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clr_tally();
    n_shift = 0; n_la = 0; n_lc = 0; n_kc = 0;
  endtask

  // One clock: inputs applied at the falling edge, outputs checked at the next one.
  task automatic cyc(input logic [3:0] k, input bit a, input bit t, input bit s,
                     input string name);
    key = k; alarm_button = a; time_button = t; one_second = s;
    @(posedge clock);
    model_step(k, a, t, s);
    @(negedge clock);
    check(name, dut_out, model_out());
    n_shift += int'(shift); n_la += int'(load_new_a);
    n_lc += int'(load_new_c); n_kc += int'(key_clear);
  endtask

  task automatic do_reset();
    key = NK; alarm_button = 0; time_button = 0; one_second = 0;
    reset = 0;
    @(negedge clock);
    @(negedge clock);
    check("reset_outputs", dut_out, 9'b0);
    model_reset();
    reset = 1;
  endtask

  typedef struct {
    logic [3:0] k;
    bit         a, t, s;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[12];
  int hold;
  logic [3:0] rk;
  bit ra, rt, rs;

  initial begin
    // Alarm view with a key held, then two digit entries with ignored time button.
    tbl[0]  = '{NK,    1'b1, 1'b0, 1'b0, 9'b000010000};
    tbl[1]  = '{4'd3,  1'b1, 1'b0, 1'b0, 9'b000010000};
    tbl[2]  = '{4'd3,  1'b1, 1'b0, 1'b0, 9'b000010000};
    tbl[3]  = '{4'd3,  1'b0, 1'b0, 1'b0, 9'b000000000};
    tbl[4]  = '{4'd3,  1'b0, 1'b0, 1'b0, 9'b100100000};
    tbl[5]  = '{4'd3,  1'b0, 1'b0, 1'b0, 9'b000100001};
    tbl[6]  = '{NK,    1'b0, 1'b0, 1'b0, 9'b000100001};
    tbl[7]  = '{NK,    1'b0, 1'b1, 1'b0, 9'b000100001};
    tbl[8]  = '{4'd9,  1'b0, 1'b0, 1'b1, 9'b100100001};
    tbl[9]  = '{NK,    1'b0, 1'b0, 1'b0, 9'b000100010};
    tbl[10] = '{4'd15, 1'b0, 1'b0, 1'b0, 9'b000100010};
    tbl[11] = '{4'd12, 1'b0, 1'b1, 1'b0, 9'b000100010};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      key = tbl[i].k; alarm_button = tbl[i].a; time_button = tbl[i].t;
      one_second = tbl[i].s;
      @(posedge clock);
      @(negedge clock);
      check($sformatf("table[%0d]", i), dut_out, tbl[i].exp);
    end

    // Four digits held three cycles each, then time button.
    do_reset(); clr_tally();
    for (int d = 1; d <= 4; d++) begin
      for (int j = 0; j < 3; j++) cyc(4'(d), 0, 0, 0, "enter4");
      cyc(NK, 0, 0, 0, "enter4");
    end
    check_int("enter4_digits", int'(digit_cnt), 4);
    cyc(NK, 0, 1, 0, "enter4_time");
    cyc(NK, 0, 0, 0, "enter4_post");
    cyc(NK, 0, 0, 0, "enter4_post");
    check_int("enter4_shifts", n_shift, 4);
    check_int("enter4_load_c", n_lc, 1);
    check_int("enter4_load_a", n_la, 0);
    check_int("enter4_key_clear", n_kc, 1);

    // Two digits, alarm ignored, then timeout after ten seconds.
    do_reset(); clr_tally();
    for (int d = 1; d <= 2; d++) begin
      cyc(4'(d), 0, 0, 0, "short"); cyc(4'(d), 0, 0, 0, "short"); cyc(NK, 0, 0, 0, "short");
    end
    for (int j = 0; j < 3; j++) cyc(NK, 1, 0, 0, "short_alarm");
    check_int("short_show_new", int'(show_new_time), 1);
    for (int j = 0; j < 10; j++) begin
      check_int("short_before_timeout", n_kc, 0);
      cyc(NK, 0, 0, 1, "short_sec");
      cyc(NK, 0, 0, 0, "short_idle");
    end
    cyc(NK, 0, 0, 0, "short_after");
    check_int("short_load_a", n_la, 0);
    check_int("short_key_clear", n_kc, 1);
    check_int("short_show_time", int'(show_new_time), 0);

    // Key 7 held for 20 cycles.
    do_reset(); clr_tally();
    for (int j = 0; j < 20; j++) cyc(4'd7, 0, 0, 0, "hold7");
    check_int("hold7_shifts", n_shift, 1);

    // Five digits, then both buttons together.
    do_reset(); clr_tally();
    for (int d = 5; d <= 9; d++) begin
      cyc(4'(d), 0, 0, 0, "five"); cyc(4'(d), 0, 0, 0, "five"); cyc(NK, 0, 0, 0, "five");
    end
    check_int("five_digits", int'(digit_cnt), 4);
    cyc(NK, 1, 1, 0, "five_both");
    cyc(NK, 0, 0, 0, "five_post");
    cyc(NK, 0, 0, 0, "five_post");
    check_int("five_shifts", n_shift, 5);
    check_int("five_load_a", n_la, 1);
    check_int("five_load_c", n_lc, 0);

    // Asynchronous reset in KEY_WAITED.
    do_reset(); clr_tally();
    cyc(4'd3, 0, 0, 0, "areset"); cyc(4'd3, 0, 0, 0, "areset");
    check_int("areset_waiting", int'(show_new_time), 1);
    reset = 0;
    #1;
    check("areset_immediate", dut_out, 9'b0);
    @(negedge clock);
    model_reset();
    reset = 1;
    for (int j = 0; j < 4; j++) cyc(NK, 0, 0, 0, "areset_after");
    check_int("areset_no_clear", n_kc, 0);

    // Randomized run against the model.
    do_reset();
    hold = 0; rk = NK;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        rk = ($urandom_range(0, 1) == 0) ? NK : 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 4);
      end
      hold--;
      ra = ($urandom_range(0, 9) == 0);
      rt = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 2) == 0);
      cyc(rk, ra, rt, rs, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_key_ctrl.md
ALARM_KEY_CTRL -- requirements
Module: alarm_key_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_SEC, default 10: seconds of inactivity before entry mode is abandoned.
REQ-002 SHALL have parameter NOKEY, default 4'd10: key code meaning "no key pressed".
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 one_second  input  1  one-cycle pulse, once per second.
REQ-006 key  input  4  keypad code; 0-9 = digit, any other value = no key.
REQ-007 alarm_button  input  1  level; high while the alarm button is held.
REQ-008 time_button  input  1  level; high while the time button is held.
REQ-009 shift  output  1  one-cycle strobe to the key register to shift in the current key.
REQ-010 load_new_a  output  1  one-cycle strobe to load the key buffer into the alarm register.
REQ-011 load_new_c  output  1  one-cycle strobe to load the key buffer into the current-time counter.
REQ-012 show_new_time  output  1  display selects the key buffer.
REQ-013 show_a  output  1  display selects the alarm time.
REQ-014 key_clear  output  1  one-cycle strobe to clear the key register.
REQ-015 digit_cnt  output  3  digits entered, 0-4, saturating.

Function
REQ-016 States SHALL be: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTERED, SHOW_ALARM, SET_ALARM, SET_TIME.
REQ-017 Outputs SHALL be Moore-decoded from state only:
- shift=1 only in KEY_STORED
- load_new_a=1 only in SET_ALARM
- load_new_c=1 only in SET_TIME
- show_new_time=1 in KEY_STORED, KEY_WAITED and KEY_ENTERED
- show_a=1 only in SHOW_ALARM
REQ-018 A key SHALL be valid only when key<=9; all other codes, including NOKEY, are treated as no key.
REQ-019 SHOW_TIME transitions, in priority order:
- alarm_button -> SHOW_ALARM
- else valid key -> KEY_STORED
- else stay
REQ-020 SHOW_ALARM SHALL stay while alarm_button=1 and go to SHOW_TIME on release.
REQ-021 KEY_STORED SHALL last exactly one cycle and always go to KEY_WAITED; digit_cnt increments on the same edge, saturating at 4.
REQ-022 KEY_WAITED SHALL go to KEY_ENTERED once no valid key is present; a held key SHALL NOT produce a second shift.
REQ-023 KEY_ENTERED transitions, in priority order:
- timeout -> SHOW_TIME
- alarm_button and digit_cnt==4 -> SET_ALARM
- time_button and digit_cnt==4 -> SET_TIME
- valid key -> KEY_STORED
- else stay
REQ-024 Buttons in KEY_ENTERED with digit_cnt<4 SHALL be ignored; the FSM stays in KEY_ENTERED.
REQ-025 If both buttons are high with digit_cnt==4, alarm SHALL win.
REQ-026 SET_ALARM and SET_TIME SHALL each last one cycle and then go to SHOW_TIME.
REQ-027 A fifth or later digit SHALL still produce shift (oldest digit shifted out); digit_cnt stays at 4.
REQ-028 Timeout counter:
- counts one_second pulses while in KEY_WAITED or KEY_ENTERED
- clears to 0 in every other state
- timeout is true when the count equals TIMEOUT_SEC
- width = ceil(log2(TIMEOUT_SEC+1))
REQ-029 Timeout in KEY_WAITED SHALL also go to SHOW_TIME, even with a key still held.
REQ-030 key_clear SHALL pulse for one cycle on every transition into SHOW_TIME from any key-entry or set state; digit_cnt SHALL be 0 on that cycle.
REQ-031 If one_second coincides with a valid key in KEY_ENTERED and the count is below TIMEOUT_SEC-1, the key SHALL be taken and the counter cleared.

Reset
REQ-032 While reset=0, the state SHALL be SHOW_TIME asynchronously, with the timeout counter=0, digit_cnt=0 and all strobes and show outputs 0.
REQ-033 Reset asserted mid-entry SHALL discard the entry; the next release starts in SHOW_TIME with no key_clear pulse.

Verification
REQ-034 Enter 1,2,3,4 (each key held 3 cycles, then NOKEY), then time_button -> exactly 4 shift pulses, digit_cnt=4, one load_new_c pulse, then key_clear and SHOW_TIME.
REQ-035 Enter 1,2 then alarm_button -> no load_new_a, state stays KEY_ENTERED; wait 10 one_second pulses -> key_clear, SHOW_TIME.
REQ-036 Hold key 7 for 20 cycles -> exactly one shift pulse.
REQ-037 Enter 5 digits then alarm_button with time_button -> 5 shift pulses, digit_cnt=4, one load_new_a, no load_new_c.
REQ-038 In SHOW_TIME hold alarm_button 6 cycles with key=3 -> show_a=1 for the hold, no shift, return to SHOW_TIME.
REQ-039 Drop reset to 0 in KEY_WAITED -> all outputs 0 immediately, before the next edge.
